// File: rtl/rpmb_host.sv
// Host-side responder for the RPMB bridge handshake bus: holds the MSX with rwait,
// fetches address/data over md, services the cycle on a local mem/IO port.
// Optional RPMB_TIMEOUT_EN: bounds the wait for mem_ack and raises a sticky err.
module rpmb_host #(
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        rw,
   input  logic        rmirq,
   output logic        a0,
   output logic        rwait,
   inout  wire  [15:0] md,
   output logic        rint,
   input  logic        irq_in,
   output logic [15:0] mem_addr,
   output logic        mem_io,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM, HOLD, RELEASE} state_t;

   localparam logic [7:0] SET_LAST = 8'(SETTLE - 1);
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic        cs_m, cs_s, cs_p;
   logic        a0_n, rwait_n, md_oe, md_oe_n, wr_q, wr_n, io_n, rd_n, wrs_n;
   logic        abrt, abrt_n, err_q, err_n;
   logic [7:0]  rdata_q, rdata_n, wdata_n;
   logic [15:0] addr_n;
   logic        cs_fall, settled, done;
   logic [7:0]  rd_val;

   // cs is asynchronous to clk; edge detect runs on the synchronized copy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cs_m <= 1'b1;
         cs_s <= 1'b1;
         cs_p <= 1'b1;
         rint <= 1'b1;
      end else begin
         cs_m <= cs;
         cs_s <= cs_m;
         cs_p <= cs_s;
         rint <= ~irq_in;
      end
   end

   assign cs_fall = cs_p & ~cs_s;
   assign settled = (cnt == SET_LAST);
   assign busy    = (state != IDLE);
   assign md[7:0]  = md_oe ? rdata_q : 8'hzz;
   assign md[15:8] = 8'hzz;

`ifdef RPMB_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         a0        <= 1'b0;
         rwait     <= 1'b1;
         md_oe     <= 1'b0;
         rdata_q   <= 8'd0;
         mem_addr  <= 16'd0;
         mem_io    <= 1'b0;
         wr_q      <= 1'b0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_wdata <= 8'd0;
         abrt      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         a0        <= a0_n;
         rwait     <= rwait_n;
         md_oe     <= md_oe_n;
         rdata_q   <= rdata_n;
         mem_addr  <= addr_n;
         mem_io    <= io_n;
         wr_q      <= wr_n;
         mem_rd    <= rd_n;
         mem_wr    <= wrs_n;
         mem_wdata <= wdata_n;
         abrt      <= abrt_n;
         err_q     <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      a0_n    = a0;
      rwait_n = rwait;
      md_oe_n = md_oe;
      rdata_n = rdata_q;
      addr_n  = mem_addr;
      io_n    = mem_io;
      wr_n    = wr_q;
      rd_n    = mem_rd;
      wrs_n   = mem_wr;
      wdata_n = mem_wdata;
      abrt_n  = abrt;
      err_n   = err_q;
      done    = mem_ack;
      rd_val  = mem_rdata;

      case (state)
         IDLE: begin
            a0_n    = 1'b0;
            md_oe_n = 1'b0;
            if (cs_fall) begin
               state_n = ADDR;
               rwait_n = 1'b0;
               cnt_n   = 8'd0;
            end
         end
         ADDR: begin
            if (cs_s) begin
               state_n = IDLE;
               rwait_n = 1'b1;
               a0_n    = 1'b0;
            end else if (settled) begin
               addr_n  = md;
               io_n    = rmirq;
               wr_n    = rw;
               a0_n    = 1'b1;
               cnt_n   = 8'd0;
               state_n = DATA;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         DATA: begin
            if (cs_s) begin
               state_n = IDLE;
               rwait_n = 1'b1;
               a0_n    = 1'b0;
            end else if (settled) begin
               if (wr_q) begin
                  wdata_n = md[7:0];
                  wrs_n   = 1'b1;
               end else begin
                  rd_n = 1'b1;
               end
               cnt_n   = 8'd0;
               abrt_n  = 1'b0;
               state_n = MEM;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         MEM: begin
            // bus abort cannot cancel a started access; remember it until ack
            if (cs_s) abrt_n = 1'b1;
            if (cnt != TO_LAST) cnt_n = cnt + 8'd1;
`ifdef RPMB_TIMEOUT_EN
            if (!mem_ack && cnt == TO_LAST) begin
               done   = 1'b1;
               rd_val = 8'hFF;
               err_n  = 1'b1;
            end
`endif
            if (done) begin
               rd_n  = 1'b0;
               wrs_n = 1'b0;
               cnt_n = 8'd0;
               if (abrt || cs_s) begin
                  state_n = IDLE;
                  rwait_n = 1'b1;
                  a0_n    = 1'b0;
               end else if (!wr_q) begin
                  rdata_n = rd_val;
                  md_oe_n = 1'b1;
                  state_n = HOLD;
               end else begin
                  rwait_n = 1'b1;
                  state_n = RELEASE;
               end
            end
         end
         HOLD: begin
            if (settled) begin
               rwait_n = 1'b1;
               state_n = RELEASE;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         RELEASE: begin
            rwait_n = 1'b1;
            if (cs_s) begin
               md_oe_n = 1'b0;
               a0_n    = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
